rob_commit_ctrl: RTL and testbench

Commit-side controller for the 32-entry reorder buffer. Tracks per-entry valid/done/exception/store status, retires up to two in-order completed entries per cycle from the current head, and drives the commit count back to the head/tail pointer block. A faulting entry at the head triggers a flush-and-recover state machine that clears the buffer and stalls allocation.

---
 rtl/rob_commit_ctrl_pkg.sv | 33 +++
 rtl/rob_commit_if.sv | 66 ++++++
 rtl/rob_commit_select.sv | 56 +++++
 rtl/rob_commit_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rob_commit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_ctrl_pkg
// Description : Shared constants, FSM state encoding and per-entry status
//               type for the reorder-buffer commit controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_commit_ctrl_pkg;

  // Default ROB index width and the matching buffer depth.
  localparam int INDEX_WIDTH_DEF = 5;
  localparam int ROB_DEPTH       = 1 << INDEX_WIDTH_DEF;

  // Commit FSM state encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  // Status of one ROB entry as seen by the commit selector.
  typedef struct packed {
    logic valid;
    logic done;
    logic exc;
    logic store;
  } entry_status_t;

  // Entry has completed cleanly and is eligible to retire (store gating aside).
  function automatic logic entry_retirable(input entry_status_t s);
    return s.valid & s.done & ~s.exc;
  endfunction

endpackage : rob_commit_ctrl_pkg
`default_nettype wire

// File: rtl/rob_commit_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_if
// Description : Dispatch/writeback/LSQ/retire signal bundle of the ROB commit
//               controller. master = environment side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_commit_if #(
  parameter int INDEX_WIDTH = 5
);
  logic [INDEX_WIDTH-1:0] head_i;

  logic                   alloc1_valid_i;
  logic [INDEX_WIDTH-1:0] alloc1_idx_i;
  logic                   alloc1_store_i;
  logic                   alloc2_valid_i;
  logic [INDEX_WIDTH-1:0] alloc2_idx_i;
  logic                   alloc2_store_i;

  logic                   wb1_valid_i;
  logic [INDEX_WIDTH-1:0] wb1_idx_i;
  logic                   wb1_exc_i;
  logic                   wb2_valid_i;
  logic [INDEX_WIDTH-1:0] wb2_idx_i;
  logic                   wb2_exc_i;

  logic                   st_commit_ready_i;
  logic                   st_commit_valid_o;
  logic [INDEX_WIDTH-1:0] st_commit_idx_o;

  logic [1:0]             comcnt_o;
  logic                   ret0_valid_o;
  logic [INDEX_WIDTH-1:0] ret0_idx_o;
  logic                   ret1_valid_o;
  logic [INDEX_WIDTH-1:0] ret1_idx_o;

  logic                   flush_o;
  logic [INDEX_WIDTH-1:0] flush_idx_o;
  logic                   stall_alloc_o;

  modport master (
    output head_i,
    output alloc1_valid_i, alloc1_idx_i, alloc1_store_i,
    output alloc2_valid_i, alloc2_idx_i, alloc2_store_i,
    output wb1_valid_i, wb1_idx_i, wb1_exc_i,
    output wb2_valid_i, wb2_idx_i, wb2_exc_i,
    output st_commit_ready_i,
    input  st_commit_valid_o, st_commit_idx_o,
    input  comcnt_o, ret0_valid_o, ret0_idx_o, ret1_valid_o, ret1_idx_o,
    input  flush_o, flush_idx_o, stall_alloc_o
  );

  modport slave (
    input  head_i,
    input  alloc1_valid_i, alloc1_idx_i, alloc1_store_i,
    input  alloc2_valid_i, alloc2_idx_i, alloc2_store_i,
    input  wb1_valid_i, wb1_idx_i, wb1_exc_i,
    input  wb2_valid_i, wb2_idx_i, wb2_exc_i,
    input  st_commit_ready_i,
    output st_commit_valid_o, st_commit_idx_o,
    output comcnt_o, ret0_valid_o, ret0_idx_o, ret1_valid_o, ret1_idx_o,
    output flush_o, flush_idx_o, stall_alloc_o
  );

endinterface : rob_commit_if
`default_nettype wire

// File: rtl/rob_commit_select.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_select
// Description : Two-slot in-order commit selection and single-store
//               arbitration for the ROB commit controller. Purely
//               combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_select
  import rob_commit_ctrl_pkg::*;
#(
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
  input  logic                   en_i,        // controller is in normal commit mode
  input  entry_status_t          slot0_i,
  input  entry_status_t          slot1_i,
  input  logic [INDEX_WIDTH-1:0] idx0_i,
  input  logic [INDEX_WIDTH-1:0] idx1_i,
  input  logic                   st_ready_i,
  output logic                   commit0_o,
  output logic                   commit1_o,
  output logic [1:0]             comcnt_o,
  output logic                   st_valid_o,
  output logic [INDEX_WIDTH-1:0] st_idx_o,
  output logic                   exc_head_o
);

  logic ok0;
  logic ok1;
  logic offer0;
  logic offer1;

  // Slot qualification, in-order commit and one-store-per-cycle arbitration.
  always_comb begin
    ok0 = en_i & entry_retirable(slot0_i);
    ok1 = en_i & entry_retirable(slot1_i);

    commit0_o = ok0 & (~slot0_i.store | st_ready_i);
    // Slot 1 may only retire behind slot 0, and may only be a store when
    // slot 0 did not already use the single LSQ commit port.
    commit1_o = commit0_o & ok1 & (~slot1_i.store | (st_ready_i & ~slot0_i.store));

    // The offered store is the first store in the in-order committable run,
    // independent of whether the LSQ is ready this cycle.
    offer0 = ok0 & slot0_i.store;
    offer1 = ok0 & ~slot0_i.store & ok1 & slot1_i.store;

    st_valid_o = offer0 | offer1;
    st_idx_o   = offer0 ? idx0_i : (offer1 ? idx1_i : '0);

    comcnt_o   = {1'b0, commit0_o} + {1'b0, commit1_o};
    exc_head_o = en_i & slot0_i.valid & slot0_i.done & slot0_i.exc;
  end

endmodule : rob_commit_select
`default_nettype wire

// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_ctrl
// Description : Commit-side controller of the reorder buffer. Holds the
//               per-entry valid/done/exc/store bitmaps, retires up to two
//               completed entries per cycle from the head, and runs the
//               flush/recover sequence when a faulting entry reaches the head.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int INDEX_WIDTH    = INDEX_WIDTH_DEF,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  rob_commit_if.slave  bus
);

  // The default configuration picks up the shared depth constant directly.
  localparam int DEPTH = (INDEX_WIDTH == INDEX_WIDTH_DEF) ? ROB_DEPTH : (1 << INDEX_WIDTH);
  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [DEPTH-1:0]       done_q,  done_d;
  logic [DEPTH-1:0]       exc_q,   exc_d;
  logic [DEPTH-1:0]       store_q, store_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [INDEX_WIDTH-1:0] flush_idx_q, flush_idx_d;

  logic [INDEX_WIDTH-1:0] idx0;
  logic [INDEX_WIDTH-1:0] idx1;
  entry_status_t          slot0;
  entry_status_t          slot1;
  logic                   commit0;
  logic                   commit1;
  logic [1:0]             comcnt;
  logic                   st_valid;
  logic [INDEX_WIDTH-1:0] st_idx;
  logic                   exc_head;
  logic                   idle;

  assign idle = (state_q == ST_IDLE);
  // Slot 1 wraps naturally at the index width (last entry -> entry 0).
  assign idx0 = bus.head_i;
  assign idx1 = bus.head_i + IDX_ONE;

  // Gather the registered status of the two commit slots.
  always_comb begin
    slot0 = '{valid: valid_q[idx0], done: done_q[idx0], exc: exc_q[idx0], store: store_q[idx0]};
    slot1 = '{valid: valid_q[idx1], done: done_q[idx1], exc: exc_q[idx1], store: store_q[idx1]};
  end

  rob_commit_select #(
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_select (
    .en_i       (idle),
    .slot0_i    (slot0),
    .slot1_i    (slot1),
    .idx0_i     (idx0),
    .idx1_i     (idx1),
    .st_ready_i (bus.st_commit_ready_i),
    .commit0_o  (commit0),
    .commit1_o  (commit1),
    .comcnt_o   (comcnt),
    .st_valid_o (st_valid),
    .st_idx_o   (st_idx),
    .exc_head_o (exc_head)
  );

  // Flush/recover sequencing and latching of the faulting index.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_idx_d = flush_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_head) begin
          state_d     = ST_FLUSH;
          flush_idx_d = idx0;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RECOVER;
        cnt_d   = CNT_LOAD;
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bitmap next state; later assignments win: writeback < commit-clear < alloc.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    store_d = store_q;
    if (idle) begin
      if (bus.wb1_valid_i && valid_q[bus.wb1_idx_i]) begin
        done_d[bus.wb1_idx_i] = 1'b1;
        exc_d[bus.wb1_idx_i]  = bus.wb1_exc_i;
      end
      if (bus.wb2_valid_i && valid_q[bus.wb2_idx_i]) begin
        done_d[bus.wb2_idx_i] = 1'b1;
        exc_d[bus.wb2_idx_i]  = bus.wb2_exc_i;
      end
      if (commit0) begin
        valid_d[idx0] = 1'b0;
        done_d[idx0]  = 1'b0;
      end
      if (commit1) begin
        valid_d[idx1] = 1'b0;
        done_d[idx1]  = 1'b0;
      end
      if (bus.alloc1_valid_i) begin
        valid_d[bus.alloc1_idx_i] = 1'b1;
        done_d[bus.alloc1_idx_i]  = 1'b0;
        exc_d[bus.alloc1_idx_i]   = 1'b0;
        store_d[bus.alloc1_idx_i] = bus.alloc1_store_i;
      end
      if (bus.alloc2_valid_i) begin
        valid_d[bus.alloc2_idx_i] = 1'b1;
        done_d[bus.alloc2_idx_i]  = 1'b0;
        exc_d[bus.alloc2_idx_i]   = 1'b0;
        store_d[bus.alloc2_idx_i] = bus.alloc2_store_i;
      end
    end else if (state_q == ST_FLUSH) begin
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
      store_d = '0;
    end
  end

  // State, counter, flush index and status bitmap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      flush_idx_q <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      exc_q       <= '0;
      store_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_idx_q <= flush_idx_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      exc_q       <= exc_d;
      store_q     <= store_d;
    end
  end

  // Retire/store outputs are zero whenever their slot is not active.
  assign bus.comcnt_o          = comcnt;
  assign bus.ret0_valid_o      = commit0;
  assign bus.ret0_idx_o        = commit0 ? idx0 : '0;
  assign bus.ret1_valid_o      = commit1;
  assign bus.ret1_idx_o        = commit1 ? idx1 : '0;
  assign bus.st_commit_valid_o = st_valid;
  assign bus.st_commit_idx_o   = st_idx;
  assign bus.flush_o           = (state_q == ST_FLUSH);
  assign bus.flush_idx_o       = flush_idx_q;
  assign bus.stall_alloc_o     = ~idle;

`ifndef SYNTHESIS
  // Two dispatch ports must never allocate the same entry in one cycle.
  a_alloc_distinct: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.alloc1_valid_i && bus.alloc2_valid_i && (bus.alloc1_idx_i == bus.alloc2_idx_i)));
`endif

endmodule : rob_commit_ctrl
`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_commit_ctrl
// Description : Directed, table-driven bench for rob_commit_ctrl plus a
//               hand-written asynchronous-reset-during-recover sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_commit_ctrl;

  localparam int IW = 5;

  typedef struct packed {
    logic [IW-1:0] head;
    logic          rdy;
    logic          a1v; logic [IW-1:0] a1i; logic a1s;
    logic          a2v; logic [IW-1:0] a2i; logic a2s;
    logic          w1v; logic [IW-1:0] w1i; logic w1e;
    logic          w2v; logic [IW-1:0] w2i; logic w2e;
  } in_t;

  typedef struct packed {
    logic [1:0]    cnt;
    logic          r0v; logic [IW-1:0] r0i;
    logic          r1v; logic [IW-1:0] r1i;
    logic          stv; logic [IW-1:0] sti;
    logic          fl;  logic [IW-1:0] fli;
    logic          stall;
  } outs_t;

  typedef struct {
    in_t   in_v;
    outs_t exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  vec_t vecs[$];

  rob_commit_if #(.INDEX_WIDTH(IW)) bus ();

  rob_commit_ctrl #(
    .INDEX_WIDTH    (IW),
    .RECOVER_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk_in(input logic [IW-1:0] h, input logic r,
                                input logic a1v, input logic [IW-1:0] a1i, input logic a1s,
                                input logic a2v, input logic [IW-1:0] a2i, input logic a2s,
                                input logic w1v, input logic [IW-1:0] w1i, input logic w1e,
                                input logic w2v, input logic [IW-1:0] w2i, input logic w2e);
    in_t v;
    v = '{head: h, rdy: r, a1v: a1v, a1i: a1i, a1s: a1s, a2v: a2v, a2i: a2i, a2s: a2s,
          w1v: w1v, w1i: w1i, w1e: w1e, w2v: w2v, w2i: w2i, w2e: w2e};
    return v;
  endfunction

  function automatic in_t nop(input logic [IW-1:0] h, input logic r);
    return mk_in(h, r, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
  endfunction

  function automatic outs_t mk_out(input logic [1:0] cnt,
                                   input logic r0v, input logic [IW-1:0] r0i,
                                   input logic r1v, input logic [IW-1:0] r1i,
                                   input logic stv, input logic [IW-1:0] sti,
                                   input logic fl,  input logic [IW-1:0] fli,
                                   input logic stall);
    outs_t o;
    o = '{cnt: cnt, r0v: r0v, r0i: r0i, r1v: r1v, r1i: r1i, stv: stv, sti: sti,
          fl: fl, fli: fli, stall: stall};
    return o;
  endfunction

  // Quiet outputs with a given held flush index and stall level.
  function automatic outs_t quiet(input logic [IW-1:0] fli, input logic stall);
    return mk_out(0, 0,0, 0,0, 0,0, 0, fli, stall);
  endfunction

  task automatic add(input in_t i, input outs_t o);
    vec_t v;
    v.in_v = i;
    v.exp  = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t v);
    bus.head_i            = v.head;
    bus.st_commit_ready_i = v.rdy;
    bus.alloc1_valid_i    = v.a1v; bus.alloc1_idx_i = v.a1i; bus.alloc1_store_i = v.a1s;
    bus.alloc2_valid_i    = v.a2v; bus.alloc2_idx_i = v.a2i; bus.alloc2_store_i = v.a2s;
    bus.wb1_valid_i       = v.w1v; bus.wb1_idx_i    = v.w1i; bus.wb1_exc_i      = v.w1e;
    bus.wb2_valid_i       = v.w2v; bus.wb2_idx_i    = v.w2i; bus.wb2_exc_i      = v.w2e;
  endtask

  function automatic outs_t sample();
    return '{cnt: bus.comcnt_o, r0v: bus.ret0_valid_o, r0i: bus.ret0_idx_o,
             r1v: bus.ret1_valid_o, r1i: bus.ret1_idx_o,
             stv: bus.st_commit_valid_o, sti: bus.st_commit_idx_o,
             fl: bus.flush_o, fli: bus.flush_idx_o, stall: bus.stall_alloc_o};
  endfunction

  task automatic chk(input string name, input outs_t act, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got cnt=%0d r0=%0b/%0d r1=%0b/%0d st=%0b/%0d fl=%0b/%0d stall=%0b, expected cnt=%0d r0=%0b/%0d r1=%0b/%0d st=%0b/%0d fl=%0b/%0d stall=%0b",
               name, act.cnt, act.r0v, act.r0i, act.r1v, act.r1i, act.stv, act.sti, act.fl, act.fli, act.stall,
               exp.cnt, exp.r0v, exp.r0i, exp.r1v, exp.r1i, exp.stv, exp.sti, exp.fl, exp.fli, exp.stall);
    end
  endtask

  // Safety net: the directed run ends long before this.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    // ---------------- vector table: one row per clock cycle ----------------
    add(nop(0,0),                                          quiet(0,0));                          // reset state
    add(mk_in(0,0, 1,0,0, 1,1,0, 0,0,0, 0,0,0),            quiet(0,0));                          // alloc 0,1
    add(mk_in(0,0, 0,0,0, 0,0,0, 1,0,0, 1,1,0),            quiet(0,0));                          // wb 0,1
    add(nop(0,0),                                          mk_out(2, 1,0, 1,1, 0,0, 0,0, 0));    // dual commit
    add(nop(0,0),                                          quiet(0,0));                          // bits cleared
    add(mk_in(0,0, 1,31,0, 1,0,0, 0,0,0, 0,0,0),           quiet(0,0));                          // alloc 31,0
    add(mk_in(0,0, 0,0,0, 0,0,0, 1,31,0, 1,0,0),           quiet(0,0));                          // wb 31,0 (0 not done yet)
    add(nop(31,0),                                         mk_out(2, 1,31, 1,0, 0,0, 0,0, 0));   // wrap
    add(mk_in(0,0, 1,4,1, 1,5,1, 0,0,0, 0,0,0),            quiet(0,0));                          // alloc stores 4,5
    add(mk_in(0,0, 0,0,0, 0,0,0, 1,4,0, 1,5,0),            quiet(0,0));                          // wb 4,5
    add(nop(4,1),                                          mk_out(1, 1,4, 0,0, 1,4, 0,0, 0));    // one store only
    add(nop(5,0),                                          mk_out(0, 0,0, 0,0, 1,5, 0,0, 0));    // offered, not ready
    add(nop(5,1),                                          mk_out(1, 1,5, 0,0, 1,5, 0,0, 0));    // store 5 commits
    add(nop(5,1),                                          quiet(0,0));                          // cleared
    add(mk_in(0,0, 1,8,0, 1,9,1, 0,0,0, 0,0,0),            quiet(0,0));                          // alloc 8 ns, 9 st
    add(mk_in(0,0, 0,0,0, 0,0,0, 1,8,0, 1,9,0),            quiet(0,0));                          // wb 8,9
    add(nop(8,0),                                          mk_out(1, 1,8, 0,0, 1,9, 0,0, 0));    // slot1 store offered
    add(nop(9,1),                                          mk_out(1, 1,9, 0,0, 1,9, 0,0, 0));
    add(mk_in(0,0, 1,2,0, 1,3,0, 0,0,0, 0,0,0),            quiet(0,0));                          // alloc 2,3
    add(mk_in(0,0, 1,12,0, 0,0,0, 1,2,0, 1,3,1),           quiet(0,0));                          // wb 2 ok, 3 exc; alloc 12
    add(mk_in(2,0, 0,0,0, 0,0,0, 1,12,0, 0,0,0),           mk_out(1, 1,2, 0,0, 0,0, 0,0, 0));    // slot1 exc blocks
    add(nop(3,0),                                          quiet(0,0));                          // exc at head seen
    add(nop(3,0),                                          mk_out(0, 0,0, 0,0, 0,0, 1,3, 1));    // FLUSH
    add(mk_in(0,0, 1,10,0, 0,0,0, 1,10,0, 0,0,0),          quiet(3,1));                          // RECOVER, inputs ignored
    add(nop(0,0),                                          quiet(3,1));                          // RECOVER last
    add(nop(12,0),                                         quiet(3,0));                          // IDLE, 12 flushed
    add(nop(10,0),                                         quiet(3,0));                          // 10 never allocated
    add(mk_in(0,0, 1,7,0, 0,0,0, 0,0,0, 0,0,0),            quiet(3,0));                          // alloc 7
    add(mk_in(0,0, 0,0,0, 0,0,0, 1,7,1, 0,0,0),            quiet(3,0));                          // wb 7 exc
    add(nop(7,1),                                          quiet(3,0));                          // exc at head
    add(nop(7,1),                                          mk_out(0, 0,0, 0,0, 0,0, 1,7, 1));    // FLUSH idx 7
    add(nop(0,1),                                          quiet(7,1));
    add(nop(0,1),                                          quiet(7,1));
    add(nop(0,1),                                          quiet(7,0));                          // stall released
    add(mk_in(0,0, 1,14,0, 0,0,0, 0,0,0, 0,0,0),           quiet(7,0));                          // alloc 14
    add(mk_in(0,0, 0,0,0, 0,0,0, 1,14,0, 0,0,0),           quiet(7,0));                          // wb 14
    add(mk_in(20,0, 1,14,0, 0,0,0, 1,14,0, 0,0,0),         quiet(7,0));                          // realloc + wb same idx
    add(nop(14,0),                                         quiet(7,0));                          // valid, not done
    add(mk_in(0,0, 0,0,0, 0,0,0, 1,14,0, 0,0,0),           quiet(7,0));                          // wb 14
    add(mk_in(14,0, 0,0,0, 0,0,0, 1,14,0, 0,0,0),          mk_out(1, 1,14, 0,0, 0,0, 0,7, 0));   // commit + wb same idx
    add(nop(14,0),                                         quiet(7,0));                          // commit-clear won

    // ---------------- reset and table application ----------------
    rst_n = 1'b0;
    drive(nop(0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in_v);
      #2;
      chk($sformatf("vec%0d", i), sample(), vecs[i].exp);
      @(negedge clk);
    end

    // ---------------- async reset in the middle of RECOVER ----------------
    drive(mk_in(0,0, 1,20,0, 0,0,0, 0,0,0, 0,0,0));
    @(negedge clk);
    drive(mk_in(0,0, 0,0,0, 0,0,0, 1,20,1, 0,0,0));
    @(negedge clk);
    drive(nop(20,0));
    #2;
    chk("rst_seq_detect", sample(), quiet(7,0));
    @(negedge clk);
    #2;
    chk("rst_seq_flush", sample(), mk_out(0, 0,0, 0,0, 0,0, 1,20, 1));
    @(negedge clk);
    #2;
    chk("rst_seq_recover", sample(), quiet(20,1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_seq_async_clear", sample(), quiet(0,0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_seq_idle_after", sample(), quiet(0,0));
    @(negedge clk);
    #2;
    chk("rst_seq_stays_idle", sample(), quiet(0,0));
    drive(mk_in(20,0, 1,21,0, 0,0,0, 0,0,0, 0,0,0));
    @(negedge clk);
    drive(mk_in(20,0, 0,0,0, 0,0,0, 1,21,0, 0,0,0));
    @(negedge clk);
    drive(nop(21,0));
    #2;
    chk("rst_seq_commit_after", sample(), mk_out(1, 1,21, 0,0, 0,0, 0,0, 0));
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rob_commit_ctrl
`default_nettype wire
